// File: rtl/systolic_result_deskew_if.sv
// ----------------------------------------------------------------------------
// systolic_result_deskew_if
// Bus bundle for the systolic result collector.
//   acc_valid, acc_in_0..7 : skewed column results from the array (upstream)
//   out_valid/out_ready    : downstream row handshake
//   out_data_0..7, out_last: aligned head row and its tile-end marker
//   overflow, level        : sticky drop flag and FIFO occupancy
// Modports: slave = collector view, master = array/consumer view.
// ----------------------------------------------------------------------------
interface systolic_result_deskew_if #(
    parameter int unsigned FIFO_DEPTH = 8
) ();
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          acc_valid;
    logic [15:0]   acc_in_0;
    logic [15:0]   acc_in_1;
    logic [15:0]   acc_in_2;
    logic [15:0]   acc_in_3;
    logic [15:0]   acc_in_4;
    logic [15:0]   acc_in_5;
    logic [15:0]   acc_in_6;
    logic [15:0]   acc_in_7;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data_0;
    logic [15:0]   out_data_1;
    logic [15:0]   out_data_2;
    logic [15:0]   out_data_3;
    logic [15:0]   out_data_4;
    logic [15:0]   out_data_5;
    logic [15:0]   out_data_6;
    logic [15:0]   out_data_7;
    logic          out_last;
    logic          overflow;
    logic [LW-1:0] level;

    modport slave (
        input  acc_valid, acc_in_0, acc_in_1, acc_in_2, acc_in_3,
               acc_in_4, acc_in_5, acc_in_6, acc_in_7, out_ready,
        output out_valid, out_data_0, out_data_1, out_data_2, out_data_3,
               out_data_4, out_data_5, out_data_6, out_data_7,
               out_last, overflow, level
    );

    modport master (
        output acc_valid, acc_in_0, acc_in_1, acc_in_2, acc_in_3,
               acc_in_4, acc_in_5, acc_in_6, acc_in_7, out_ready,
        input  out_valid, out_data_0, out_data_1, out_data_2, out_data_3,
               out_data_4, out_data_5, out_data_6, out_data_7,
               out_last, overflow, level
    );
endinterface

// File: rtl/systolic_result_deskew.sv
// ----------------------------------------------------------------------------
// systolic_result_deskew
// Realigns the diagonal result wavefront of the 8x8 fp16 systolic array into
// full row vectors, buffers them in a show-ahead FIFO and hands them
// downstream with a per-tile last marker.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   clear : synchronous flush (FIFO, valid pipe, row counter, overflow)
//   bus   : systolic_result_deskew_if.slave (array inputs, output handshake)
// ----------------------------------------------------------------------------
module systolic_result_deskew #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TILE_ROWS  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    systolic_result_deskew_if.slave  bus
);
    localparam int unsigned NCOL = 8;
    localparam int unsigned DW   = 16;
    localparam int unsigned SKEW = NCOL - 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned CW   = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
    localparam int unsigned RW   = NCOL * DW + 1;

    logic [DW-1:0]   acc_in      [NCOL];
    logic [DW-1:0]   col_aligned [NCOL];

    logic [SKEW-1:0] valid_sr_q, valid_sr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   row_cnt_q, row_cnt_d;
    logic            overflow_q, overflow_d;
    logic [RW-1:0]   mem_q [FIFO_DEPTH];

    logic            row_valid_c;
    logic            full_c;
    logic            pop_c;
    logic            push_c;
    logic            drop_c;
    logic [RW-1:0]   wr_row_c;
    logic [RW-1:0]   head_c;

    assign acc_in[0] = bus.acc_in_0;
    assign acc_in[1] = bus.acc_in_1;
    assign acc_in[2] = bus.acc_in_2;
    assign acc_in[3] = bus.acc_in_3;
    assign acc_in[4] = bus.acc_in_4;
    assign acc_in[5] = bus.acc_in_5;
    assign acc_in[6] = bus.acc_in_6;
    assign acc_in[7] = bus.acc_in_7;

    // Column j gets SKEW-j free-running stages so every column lands at T+7.
    for (genvar j = 0; j < int'(SKEW); j++) begin : g_dly
        localparam int unsigned STAGES = SKEW - j;
        logic [DW-1:0] dly_q [STAGES];
        logic [DW-1:0] dly_d [STAGES];

        always_comb begin
            dly_d[0] = acc_in[j];
            for (int k = 1; k < int'(STAGES); k++) begin
                dly_d[k] = dly_q[k-1];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < int'(STAGES); k++) begin
                    dly_q[k] <= '0;
                end
            end else begin
                dly_q <= dly_d;
            end
        end

        assign col_aligned[j] = dly_q[STAGES-1];
    end

    // Last column arrives already aligned.
    assign col_aligned[SKEW] = acc_in[SKEW];

    // FIFO control; a full FIFO still accepts when the head leaves this edge.
    assign row_valid_c = valid_sr_q[SKEW-1];
    assign full_c      = (level_q == LW'(FIFO_DEPTH));
    assign pop_c       = (level_q != '0) && bus.out_ready;
    assign push_c      = row_valid_c && (!full_c || pop_c);
    assign drop_c      = row_valid_c && !push_c;

    // Row payload: aligned columns plus the tile-end tag in the MSB.
    always_comb begin
        wr_row_c         = '0;
        wr_row_c[RW-1]   = (row_cnt_q == CW'(TILE_ROWS - 1));
        for (int j = 0; j < int'(NCOL); j++) begin
            wr_row_c[j*DW +: DW] = col_aligned[j];
        end
    end

    // Next-state logic; clear overrides any push or pop.
    always_comb begin
        valid_sr_d = {valid_sr_q[SKEW-2:0], bus.acc_valid};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        row_cnt_d  = row_cnt_q;
        overflow_d = overflow_q | drop_c;

        if (push_c) begin
            wr_ptr_d  = wr_ptr_q + AW'(1);
            row_cnt_d = (row_cnt_q == CW'(TILE_ROWS - 1)) ? '0 : row_cnt_q + CW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (clear) begin
            valid_sr_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            row_cnt_d  = '0;
            overflow_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_sr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_sr_q <= valid_sr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Row storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c && !clear) begin
            mem_q[wr_ptr_q] <= wr_row_c;
        end
    end

    // Show-ahead head, forced to zero while the FIFO is empty.
    assign head_c = (level_q != '0) ? mem_q[rd_ptr_q] : '0;

    assign bus.out_valid  = (level_q != '0);
    assign bus.out_last   = head_c[RW-1];
    assign bus.out_data_0 = head_c[0*DW +: DW];
    assign bus.out_data_1 = head_c[1*DW +: DW];
    assign bus.out_data_2 = head_c[2*DW +: DW];
    assign bus.out_data_3 = head_c[3*DW +: DW];
    assign bus.out_data_4 = head_c[4*DW +: DW];
    assign bus.out_data_5 = head_c[5*DW +: DW];
    assign bus.out_data_6 = head_c[6*DW +: DW];
    assign bus.out_data_7 = head_c[7*DW +: DW];
    assign bus.overflow   = overflow_q;
    assign bus.level      = level_q;

endmodule

// File: tb/tb_systolic_result_deskew.sv
// ----------------------------------------------------------------------------
// tb_systolic_result_deskew
// Directed bench for systolic_result_deskew. Rows are injected through a
// small skew model (column j of a row driven j cycles after its acc_valid);
// row k of a sequence with base B carries B+8k+j on column j.
// ----------------------------------------------------------------------------
module tb_systolic_result_deskew;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TILE  = 8;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    always #5 clk = ~clk;

    systolic_result_deskew_if #(.FIFO_DEPTH(DEPTH)) bus ();

    systolic_result_deskew #(
        .FIFO_DEPTH (DEPTH),
        .TILE_ROWS  (TILE)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .clear (clr),
        .bus   (bus)
    );

    int nchk  = 0;
    int nfail = 0;

    // Launch history: entry k is the row launched k cycles ago.
    logic        hv [8];
    logic [15:0] hb [8];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] row_of(input logic [15:0] base);
        logic [127:0] r;
        for (int j = 0; j < 8; j++) r[j*16 +: 16] = base + 16'(j);
        return r;
    endfunction

    function automatic logic [127:0] out_row();
        return {bus.out_data_7, bus.out_data_6, bus.out_data_5, bus.out_data_4,
                bus.out_data_3, bus.out_data_2, bus.out_data_1, bus.out_data_0};
    endfunction

    task automatic drive_cols();
        bus.acc_valid = hv[0];
        bus.acc_in_0  = hv[0] ? hb[0]         : 16'd0;
        bus.acc_in_1  = hv[1] ? hb[1] + 16'd1 : 16'd0;
        bus.acc_in_2  = hv[2] ? hb[2] + 16'd2 : 16'd0;
        bus.acc_in_3  = hv[3] ? hb[3] + 16'd3 : 16'd0;
        bus.acc_in_4  = hv[4] ? hb[4] + 16'd4 : 16'd0;
        bus.acc_in_5  = hv[5] ? hb[5] + 16'd5 : 16'd0;
        bus.acc_in_6  = hv[6] ? hb[6] + 16'd6 : 16'd0;
        bus.acc_in_7  = hv[7] ? hb[7] + 16'd7 : 16'd0;
    endtask

    // One cycle: launch (or not) a row, then move to 1 time unit past the edge.
    task automatic step(input logic v, input logic [15:0] base);
        for (int k = 7; k > 0; k--) begin
            hv[k] = hv[k-1];
            hb[k] = hb[k-1];
        end
        hv[0] = v;
        hb[0] = base;
        drive_cols();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'd0);
    endtask

    // Back-to-back rows with out_ready high; row r is visible 8 cycles after launch.
    task automatic stream(input int n, input logic [15:0] base, input string tag);
        for (int k = 0; k < n + 8; k++) begin
            int r;
            step(k < n, base + 16'(8 * k));
            r = k - 7;
            if (r >= 0 && r < n) begin
                chk({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
                chk({tag, "_row"},   out_row(),           row_of(base + 16'(8 * r)));
                chk({tag, "_last"},  128'(bus.out_last),  128'((r % TILE) == TILE - 1));
            end else begin
                chk({tag, "_idle"},  128'(bus.out_valid), 128'(0));
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            hv[k] = 1'b0;
            hb[k] = 16'd0;
        end
        drive_cols();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    128'(bus.out_valid), 128'(0));
        chk("rst_level",    128'(bus.level),     128'(0));
        chk("rst_overflow", 128'(bus.overflow),  128'(0));
        chk("rst_last",     128'(bus.out_last),  128'(0));
        chk("rst_data",     out_row(),           128'(0));
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single row: appears exactly 8 cycles after acc_valid
        step(1'b1, 16'h3C00);
        idle(6);
        chk("single_early", 128'(bus.out_valid), 128'(0));
        idle(1);
        chk("single_valid", 128'(bus.out_valid), 128'(1));
        chk("single_row",   out_row(),           row_of(16'h3C00));
        chk("single_last",  128'(bus.out_last),  128'(0));
        chk("single_level", 128'(bus.level),     128'(1));
        bus.out_ready = 1'b1;
        idle(1);
        chk("single_pop_valid", 128'(bus.out_valid), 128'(0));
        chk("single_pop_data",  out_row(),           128'(0));
        chk("single_pop_level", 128'(bus.level),     128'(0));
        clr = 1'b1;
        idle(1);
        clr = 1'b0;

        // Two tiles streaming with out_ready high
        stream(16, 16'h4000, "tile");

        // Backpressure: 9 rows into 8 entries, last one dropped
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) step(1'b1, 16'h5000 + 16'(8 * k));
        idle(7);
        chk("bp_level",    128'(bus.level),     128'(8));
        chk("bp_overflow", 128'(bus.overflow),  128'(1));
        chk("bp_valid",    128'(bus.out_valid), 128'(1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_drain_row",  out_row(),          row_of(16'h5000 + 16'(8 * i)));
            chk("bp_drain_last", 128'(bus.out_last), 128'(i == 7));
            idle(1);
        end
        chk("bp_empty_valid",  128'(bus.out_valid), 128'(0));
        chk("bp_empty_level",  128'(bus.level),     128'(0));
        chk("bp_sticky_ovf",   128'(bus.overflow),  128'(1));

        // Full FIFO with a pop on the same edge as a new write
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("clr_overflow", 128'(bus.overflow), 128'(0));
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) step(1'b1, 16'h6000 + 16'(8 * k));
        idle(6);
        chk("fp_full_level", 128'(bus.level), 128'(8));
        bus.out_ready = 1'b1;
        idle(1);
        chk("fp_level",    128'(bus.level),    128'(8));
        chk("fp_overflow", 128'(bus.overflow), 128'(0));
        for (int i = 1; i < 9; i++) begin
            chk("fp_drain_row",  out_row(),          row_of(16'h6000 + 16'(8 * i)));
            chk("fp_drain_last", 128'(bus.out_last), 128'(i == 7));
            idle(1);
        end
        chk("fp_empty_valid", 128'(bus.out_valid), 128'(0));

        // Clear with 3 rows buffered and 2 in flight
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step(1'b1, 16'h7000 + 16'(8 * k));
        idle(5);
        chk("cl_level_before", 128'(bus.level), 128'(3));
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("cl_level",    128'(bus.level),     128'(0));
        chk("cl_valid",    128'(bus.out_valid), 128'(0));
        chk("cl_overflow", 128'(bus.overflow),  128'(0));
        chk("cl_data",     out_row(),           128'(0));
        idle(10);
        chk("cl_inflight_gone", 128'(bus.level), 128'(0));
        bus.out_ready = 1'b1;
        stream(8, 16'h8000, "cl_tile");

        // Asynchronous reset with 4 rows buffered
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b1, 16'h9000 + 16'(8 * k));
        idle(7);
        chk("ar_level_before", 128'(bus.level), 128'(4));
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", 128'(bus.out_valid), 128'(0));
        chk("ar_level", 128'(bus.level),     128'(0));
        chk("ar_data",  out_row(),           128'(0));
        chk("ar_last",  128'(bus.out_last),  128'(0));
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 16'hA000);
        idle(6);
        chk("ar_fresh_early", 128'(bus.out_valid), 128'(0));
        idle(1);
        chk("ar_fresh_valid", 128'(bus.out_valid), 128'(1));
        chk("ar_fresh_row",   out_row(),           row_of(16'hA000));
        chk("ar_fresh_level", 128'(bus.level),     128'(1));
        chk("ar_fresh_last",  128'(bus.out_last),  128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
